// File: rtl/stall_mem_pkg.sv
// Shared constants and types for the stall-injecting memory responder.
// Stall modes, FSM states and the Galois LFSR step used by the stall generator.
package stall_mem_pkg;

    localparam int STALL_NONE     = 0;
    localparam int STALL_PERIODIC = 1;
    localparam int STALL_LFSR     = 2;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    function automatic logic [15:0] lfsrStep(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/stall_mem_model_stall_gen.sv
// Stall generator: registered busy from a periodic counter or an LFSR,
// with a directed force input ORed in.
module stall_gen
    import stall_mem_pkg::*;
#(
    parameter int          STALL_MODE   = STALL_NONE,
    parameter int          STALL_PERIOD = 40,
    parameter int          STALL_LEN    = 10,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic CLK,
    input  logic RST,
    input  logic stall_force,
    output logic busy
);

    localparam int CW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    logic [CW-1:0] cnt;
    logic [15:0]   lfsr;
    logic          modeBusy;

    always_comb begin
        modeBusy = 1'b0;
        if (STALL_MODE == STALL_PERIODIC)
            modeBusy = int'(cnt) < STALL_LEN;
        else if (STALL_MODE == STALL_LFSR)
            modeBusy = int'(lfsr[7:0]) < STALL_LEN;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt  <= '0;
            lfsr <= LFSR_SEED;
            busy <= 1'b0;
        end else begin
            busy <= stall_force | modeBusy;
            lfsr <= lfsrStep(lfsr);
            if (int'(cnt) == STALL_PERIOD - 1)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/stall_mem_model.sv
// Multi-channel memory responder: round-robin arbiter, latency counter
// and handshake FSM pacing one outstanding access, stalled by stall_gen.
module stall_mem_model
    import stall_mem_pkg::*;
#(
    parameter int          NCHAN        = 2,
    parameter int          ADDR_BITS    = 16,
    parameter int          DATA_BITS    = 16,
    parameter int          RD_LATENCY   = 1,
    parameter int          STALL_MODE   = STALL_NONE,
    parameter int          STALL_PERIOD = 40,
    parameter int          STALL_LEN    = 10,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [DATA_BITS-1:0] BUSY_FILL = DATA_BITS'(16'hBEEF)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       stall_force,
    input  logic [NCHAN*ADDR_BITS-1:0] addr,
    input  logic [NCHAN*DATA_BITS-1:0] wdata,
    output logic [NCHAN*DATA_BITS-1:0] rdata,
    input  logic [NCHAN-1:0]           rvalid,
    output logic [NCHAN-1:0]           rready,
    input  logic [NCHAN-1:0]           wvalid,
    output logic [NCHAN-1:0]           wready,
    output logic                       busy
);

    localparam int PW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    state_t               state;
    logic [PW-1:0]        grant;
    logic [PW-1:0]        rrPtr;
    logic                 opWrite;
    logic [LW-1:0]        latCnt;
    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
    logic [DATA_BITS-1:0] rdHold [NCHAN];

    logic [NCHAN-1:0]     req;
    logic [PW-1:0]        pick;
    logic [PW-1:0]        idx;
    logic                 pickFound;
    logic [ADDR_BITS-1:0] gAddr;
    logic [DATA_BITS-1:0] gWdata;
    logic                 gValid;
    logic                 ackFire;

    stall_gen #(
        .STALL_MODE  (STALL_MODE),
        .STALL_PERIOD(STALL_PERIOD),
        .STALL_LEN   (STALL_LEN),
        .LFSR_SEED   (LFSR_SEED)
    ) uStall (
        .CLK        (CLK),
        .RST        (RST),
        .stall_force(stall_force),
        .busy       (busy)
    );

    assign req     = rvalid | wvalid;
    assign gAddr   = addr[int'(grant)*ADDR_BITS +: ADDR_BITS];
    assign gWdata  = wdata[int'(grant)*DATA_BITS +: DATA_BITS];
    assign gValid  = opWrite ? wvalid[grant] : rvalid[grant];
    assign ackFire = (state == ACK) && !busy && gValid;

    // First requester at or after rrPtr
    always_comb begin
        pickFound = 1'b0;
        pick      = '0;
        idx       = '0;
        for (int i = 0; i < NCHAN; i++) begin
            idx = PW'((int'(rrPtr) + i) % NCHAN);
            if (!pickFound && req[idx]) begin
                pickFound = 1'b1;
                pick      = idx;
            end
        end
    end

    always_comb begin
        rready = '0;
        wready = '0;
        rdata  = '0;
        if (ackFire) begin
            if (opWrite)
                wready[grant] = 1'b1;
            else
                rready[grant] = 1'b1;
        end
        for (int c = 0; c < NCHAN; c++) begin
            if (busy)
                rdata[c*DATA_BITS +: DATA_BITS] = BUSY_FILL;
            else if (ackFire && !opWrite && grant == PW'(c))
                rdata[c*DATA_BITS +: DATA_BITS] = mem[gAddr];
            else
                rdata[c*DATA_BITS +: DATA_BITS] = rdHold[c];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            grant   <= '0;
            rrPtr   <= '0;
            opWrite <= 1'b0;
            latCnt  <= '0;
            for (int c = 0; c < NCHAN; c++)
                rdHold[c] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!busy && pickFound) begin
                        grant   <= pick;
                        opWrite <= wvalid[pick];
                        latCnt  <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (!gValid)
                        state <= IDLE;
                    else if (!busy) begin
                        if (int'(latCnt) == RD_LATENCY - 1)
                            state <= ACK;
                        else
                            latCnt <= latCnt + LW'(1);
                    end
                end
                ACK: begin
                    if (!gValid)
                        state <= IDLE;
                    else if (!busy) begin
                        if (!opWrite)
                            rdHold[grant] <= mem[gAddr];
                        if (int'(grant) == NCHAN - 1)
                            rrPtr <= '0;
                        else
                            rrPtr <= grant + PW'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset forces IDLE, so a reset before the ACK edge drops the write
    always_ff @(posedge CLK) begin
        if (ackFire && opWrite)
            mem[gAddr] <= gWdata;
    end

endmodule
